// File: rtl/mem_arbiter_n.sv
// N-port memory arbiter: fixed or round-robin grant, one transaction
// in flight, response routing, timeout fault and spurious-response flag.
module mem_arbiter_n #(
  parameter int N_PORTS     = 3,
  parameter int RR_MODE     = 0,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [N_PORTS-1:0]    r_req,
  input  logic [N_PORTS-1:0]    r_we,
  input  logic [4*N_PORTS-1:0]  r_be,
  input  logic [32*N_PORTS-1:0] r_addr,
  input  logic [32*N_PORTS-1:0] r_wdata,
  output logic [32*N_PORTS-1:0] r_rdata,
  output logic [N_PORTS-1:0]    r_rvalid,
  output logic [N_PORTS-1:0]    r_fault,
  output logic                  m_req,
  output logic                  m_we,
  output logic [3:0]            m_be,
  output logic [31:0]           m_addr,
  output logic [31:0]           m_wdata,
  input  logic [31:0]           m_rdata,
  input  logic                  m_rvalid,
  input  logic                  m_fault,
  output logic                  busy,
  output logic [2:0]            gnt_idx,
  output logic                  spurious
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_e;

  state_e      state_q, state_d;
  logic [2:0]  idx_q, idx_d;
  logic [2:0]  last_q, last_d;
  logic        we_q, we_d;
  logic [3:0]  be_q, be_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [15:0] cnt_q, cnt_d;
  logic        spur_q, spur_d;

  logic        found;
  logic [2:0]  win;
  logic [2:0]  base;
  int          k;

  // Search order starts one past the last winner in round-robin mode.
  always_comb begin
    base = '0;
    if (RR_MODE != 0 && last_q != 3'(N_PORTS-1))
      base = last_q + 3'd1;
    found = 1'b0;
    win   = '0;
    k     = 0;
    for (int i = 0; i < N_PORTS; i++) begin
      k = int'(base) + i;
      if (k >= N_PORTS) k = k - N_PORTS;
      if (!found && r_req[k]) begin
        found = 1'b1;
        win   = 3'(k);
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    last_d   = last_q;
    we_d     = we_q;
    be_d     = be_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    cnt_d    = cnt_q;
    spur_d   = spur_q;
    r_rvalid = '0;
    r_fault  = '0;
    r_rdata  = '0;
    if ((m_rvalid || m_fault) && state_q != WAIT)
      spur_d = 1'b1;
    unique case (state_q)
      IDLE: begin
        if (found) begin
          idx_d   = win;
          last_d  = win;
          we_d    = r_we[win];
          be_d    = r_be[int'(win)*4 +: 4];
          addr_d  = r_addr[int'(win)*32 +: 32];
          wdata_d = r_wdata[int'(win)*32 +: 32];
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        cnt_d   = '0;
        state_d = WAIT;
      end
      WAIT: begin
        r_rvalid[idx_q]              = m_rvalid;
        r_fault[idx_q]               = m_fault;
        r_rdata[int'(idx_q)*32 +: 32] = m_rdata;
        if (m_rvalid || m_fault) begin
          state_d = IDLE;
        end else if (TIMEOUT_CYC != 0 &&
                     cnt_q == 16'(TIMEOUT_CYC)) begin
          r_fault[idx_q] = 1'b1;
          state_d        = IDLE;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      last_q  <= 3'(N_PORTS-1);
      we_q    <= 1'b0;
      be_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      cnt_q   <= '0;
      spur_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      last_q  <= last_d;
      we_q    <= we_d;
      be_q    <= be_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      cnt_q   <= cnt_d;
      spur_q  <= spur_d;
    end
  end

  assign m_req    = (state_q == ISSUE);
  assign m_we     = we_q;
  assign m_be     = be_q;
  assign m_addr   = addr_q;
  assign m_wdata  = wdata_q;
  assign busy     = (state_q != IDLE);
  assign gnt_idx  = idx_q;
  assign spurious = spur_q;

endmodule

// File: doc/mem_arbiter_n.md
# mem_arbiter_n

N-port memory arbiter that serialises requests from several bus masters (IF fetch, LSU, debug/DMA) onto a single memory port. It supersedes the fixed two-port data/instruction arbiter: the port count is parametrised, fixed or round-robin priority is selectable, and the grant is held for exactly one transaction until the response returns. A response timeout generates a fault, and unsolicited memory responses are flagged. It sits between the core's master ports and the memory/peripheral interconnect.

## Interface
- N_PORTS, 3: number of requesting ports, 2..8; port 0 is highest priority in fixed mode.
- RR_MODE, 0: 0 = fixed priority (lowest index wins); 1 = round-robin.
- TIMEOUT_CYC, 255: WAIT cycles before a forced fault. 0 disables the timeout. Range 0..65535.

- clk  in  1  clock; reset rst_n, asynchronous, active-low
- rst_n  in  1  asynchronous active-low reset
- r_req  in  N_PORTS  per-port request; held high until that port's r_rvalid or r_fault
- r_we  in  N_PORTS  per-port write enable
- r_be  in  4*N_PORTS  byte enables, port k at [4k+3:4k]
- r_addr  in  32*N_PORTS  address, port k at [32k+31:32k]
- r_wdata  in  32*N_PORTS  write data
- r_rdata  out  32*N_PORTS  read data; zero for non-winning ports
- r_rvalid  out  N_PORTS  one-hot response strobe
- r_fault  out  N_PORTS  one-hot fault strobe
- m_req, m_we  out  1  memory request, write enable
- m_be  out  4  memory byte enables
- m_addr, m_wdata  out  32  memory address, write data
- m_rdata  in  32  memory read data
- m_rvalid, m_fault  in  1  memory response, memory fault
- busy  out  1  FSM not in IDLE
- gnt_idx  out  3  index of the current or last winner
- spurious  out  1  sticky: m_rvalid or m_fault seen outside WAIT; cleared only by reset

## Operation
- FSM states: IDLE, ISSUE, WAIT.
- **IDLE:** if any r_req is high, arbitrate, latch the winner index and its we/be/addr/wdata into command registers, then go to ISSUE. Otherwise stay in IDLE.
- **ISSUE:** m_req=1 for exactly one cycle, driven from the command registers. Go to WAIT.
- **WAIT:** m_req=0 and m_* hold the command values.
  - m_rvalid or m_fault: forward to the winner, then go to IDLE.
  - Timeout counter == TIMEOUT_CYC with no response: r_fault[winner]=1, then go to IDLE.
- **Response routing (combinational, WAIT only):**
  - r_rvalid[w] = m_rvalid; r_fault[w] = m_fault; r_rdata[w] = m_rdata.
  - All other ports read 0.
  - If m_rvalid and m_fault are both high, both strobes pass through.
- **Fixed priority:** the lowest set r_req index wins.
- **Round-robin:** search starts at (last_q+1) mod N_PORTS. last_q updates to the winner on the IDLE->ISSUE transition and resets to N_PORTS-1, so port 0 wins first after reset.
- **Timeout counter:** 16 bits, cleared on entry to WAIT, increments each WAIT cycle. The fault fires in the cycle where the count equals TIMEOUT_CYC.
- **Late response:** a memory response arriving after a timeout lands outside WAIT. It is dropped and sets spurious.
- **Write responses:** writes expect m_rvalid as an acknowledgement; data is ignored by the requester.
- **Requester rule:** a requester whose r_req drops before its response still completes; the response is delivered regardless.

## Timing
- Reset values:
  - FSM = IDLE, last_q = N_PORTS-1, gnt_idx = 0.
  - m_req = 0, m_we = 0, m_be = 0, m_addr = 0, m_wdata = 0.
  - busy = 0, spurious = 0.
  - All r_rvalid, r_fault and r_rdata = 0.
- **Latency:** r_req seen at cycle 0 (IDLE) -> m_req at cycle 1 -> earliest response at cycle 2 (same-cycle r_rvalid) -> IDLE at cycle 3. Minimum throughput is one transaction per 3 cycles.
- **Back-to-back:** the next arbitration happens in the IDLE cycle after the response. A port that keeps r_req high after its response is treated as a new request.
- **Responses outside WAIT:** m_rvalid or m_fault in ISSUE or IDLE is ignored for routing and sets spurious.
- **Reset mid-transaction:** all state clears asynchronously and the outstanding transaction is abandoned. Any response arriving after reset release sets spurious.

## Test plan
- **Fixed priority:** N_PORTS=3, RR_MODE=0, r_req=3'b111 held, memory responds 1 cycle after m_req -> grants 0,0,0 (port 0 re-requests). After port 0 drops: ports 1 then 2. m_addr matches the winner's address in each ISSUE cycle.
- **Round-robin:** RR_MODE=1, r_req=3'b111 held, 6 transactions -> gnt_idx sequence 0,1,2,0,1,2. r_rdata=32'hA5A5_0000+k routed only to winner k.
- **Latency:** single port 1 read of addr 32'h100, memory returns 32'hDEADBEEF at cycle 2 -> r_rvalid[1] high at exactly cycle 2, busy low at cycle 3.
- **Timeout:** TIMEOUT_CYC=4, no memory response -> r_fault[0] pulses 4 cycles after WAIT entry. A later m_rvalid sets spurious=1 and produces no r_rvalid.
- **Fault pass-through:** m_fault with m_rvalid=0 in WAIT for a port 2 write (be=4'b0011) -> r_fault[2]=1, and m_we=1, m_be=4'b0011 during ISSUE.
- **Reset mid-WAIT:** assert rst_n low during WAIT -> all outputs return to reset values immediately. After release, port 0 wins first in RR mode.
